// File: rtl/alu_ctrl_fsm_pkg.sv
// alu_ctrl_fsm_pkg: op-code names, controller state encoding and instruction field positions
package alu_ctrl_fsm_pkg;
    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_AND   = 6'h03;
    localparam logic [5:0] OP_OR    = 6'h04;
    localparam logic [5:0] OP_XOR   = 6'h05;
    localparam logic [5:0] OP_NOR   = 6'h06;
    localparam logic [5:0] OP_SLT   = 6'h09;
    localparam logic [5:0] OP_SLL   = 6'h0D;
    localparam logic [5:0] OP_SRL   = 6'h0E;
    localparam logic [5:0] OP_SRA   = 6'h0F;
    localparam logic [5:0] OP_INCA  = 6'h10;
    localparam logic [5:0] OP_DECA  = 6'h11;
    localparam logic [5:0] OP_PASSA = 6'h12;
    localparam logic [5:0] OP_PASSB = 6'h13;
    localparam logic [5:0] OP_NOTA  = 6'h14;
    localparam logic [5:0] OP_NEGA  = 6'h15;
    localparam logic [5:0] OP_SLTU  = 6'h16;
    localparam logic [5:0] OP_MIN   = 6'h17;
    localparam logic [5:0] OP_MAX   = 6'h18;
    localparam logic [5:0] OP_MINU  = 6'h19;
    localparam logic [5:0] OP_MAXU  = 6'h1A;
    localparam logic [5:0] OP_ABS   = 6'h1B;
    localparam logic [5:0] OP_ANDN  = 6'h1C;
    localparam logic [5:0] OP_ORN   = 6'h1D;
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RD_HI = 25;
    localparam int RD_LO = 21;
    localparam int RA_HI = 20;
    localparam int RA_LO = 16;
    localparam int RB_HI = 15;
    localparam int RB_LO = 11;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } state_t;
endpackage

// File: rtl/alu_op_legal.sv
// alu_op_legal: combinational legality check of a 6-bit op-code
module alu_op_legal (
    input  logic [5:0] op,
    output logic       legal
);
    // one bit per op-code: 00,02-06,09,0D-0F and 10-1D are implemented
    localparam logic [63:0] LEGAL_MASK = 64'h0000_0000_3FFF_E27D;
    assign legal = LEGAL_MASK[op];
endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: accept -> read -> exec -> write-back sequencer for a combinational ALU
// Optional ALU_CTRL_FLAGS_EN adds zero/negative flags of the written-back result.
module alu_ctrl_fsm
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rf_addr_a,
    output logic [REG_AW-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    output logic [5:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              illegal,
    output logic              busy
`ifdef ALU_CTRL_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_n
`endif
);
    state_t state, state_nx;
    logic [5:0] op_q;
    logic [REG_AW-1:0] rd_q, ra_q, rb_q;
    logic [DATA_W-1:0] opa_q, opb_q, res_q;
    logic legal, accept, in_wb;
    logic unused_bits;
    assign unused_bits = ^instr[RB_LO-1:0];
    alu_op_legal u_legal (.op(instr[OP_HI:OP_LO]), .legal(legal));
    always_comb begin
        accept = instr_valid && state == IDLE;
        in_wb = state == WB;
        state_nx = state == IDLE ? (instr_valid ? (legal ? READ : ERR) : IDLE)
                 : state == READ ? EXEC
                 : state == EXEC ? WB : IDLE;
        instr_ready = state == IDLE;
        busy = state != IDLE;
        rf_addr_a = state == READ ? ra_q : '0;
        rf_addr_b = state == READ ? rb_q : '0;
        // read data arrives during EXEC; the operand registers keep it visible afterwards
        alu_operandA = state == EXEC ? rf_data_a : opa_q;
        alu_operandB = state == EXEC ? rf_data_b : opb_q;
        rf_we = in_wb && rd_q != '0;
        rf_waddr = in_wb ? rd_q : '0;
        rf_wdata = in_wb ? res_q : '0;
        illegal = state == ERR;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            alu_operation <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
`ifdef ALU_CTRL_FLAGS_EN
            flag_z <= 1'b0;
            flag_n <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= instr[OP_HI:OP_LO];
                rd_q <= REG_AW'(instr[RD_HI:RD_LO]);
                ra_q <= REG_AW'(instr[RA_HI:RA_LO]);
                rb_q <= REG_AW'(instr[RB_HI:RB_LO]);
            end
            if (state == READ)
                alu_operation <= op_q;
            if (state == EXEC) begin
                opa_q <= rf_data_a;
                opb_q <= rf_data_b;
                res_q <= alu_result;
            end
`ifdef ALU_CTRL_FLAGS_EN
            if (in_wb) begin
                flag_z <= res_q == '0;
                flag_n <= res_q[DATA_W-1];
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: random and directed stimulus against a cycle-timeline reference model
module tb_alu_ctrl_fsm;
    import alu_ctrl_fsm_pkg::*;
    logic clk, rst_n, instr_valid, instr_ready, rf_we, illegal, busy;
    logic [31:0] instr, rf_data_a, rf_data_b, alu_operandA, alu_operandB, alu_result, rf_wdata;
    logic [4:0] rf_addr_a, rf_addr_b, rf_waddr;
    logic [5:0] alu_operation;
`ifdef ALU_CTRL_FLAGS_EN
    logic flag_z, flag_n;
`endif
    logic [31:0] rf [32];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int since = 99;
    bit pl = 0;
    logic [5:0] p_op, h_op;
    logic [4:0] p_rd, p_ra, p_rb;
    logic [31:0] p_res, h_a, h_b;
    bit m_z = 0, m_n = 0;
    logic [5:0] legal_ops [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0D,
                                   6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
                                   6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D};

    alu_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_operation(alu_operation), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .illegal(illegal), .busy(busy)
`ifdef ALU_CTRL_FLAGS_EN
        , .flag_z(flag_z), .flag_n(flag_n)
`endif
    );

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, b);
        return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_DECA ? a - 1 : a ^ (b + 32'(op));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, ra, rb);
        return {op, rd, ra, rb, 11'($urandom)};
    endfunction

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        rf_data_a <= rf[rf_addr_a];
        rf_data_b <= rf[rf_addr_b];
    end
    assign alu_result = alu_fn(alu_operation, alu_operandA, alu_operandB);

    task automatic check(input string tag, input logic [63:0] got, exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // model counts cycles since acceptance: legal occupies 3 busy cycles, illegal 1
    task automatic step();
        int span;
        bit wb;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            since = 99; pl = 0; h_op = 0; h_a = 0; h_b = 0; m_z = 0; m_n = 0;
        end else if (since >= (pl ? 4 : 2) && instr_valid) begin
            p_op = instr[31:26]; p_rd = instr[25:21]; p_ra = instr[20:16]; p_rb = instr[15:11];
            pl = is_legal(p_op);
            p_res = alu_fn(p_op, rf[p_ra], rf[p_rb]);
            since = 1;
        end else begin
            if (since < 99) since++;
            if (pl && since == 2) begin h_op = p_op; h_a = rf[p_ra]; h_b = rf[p_rb]; end
            if (pl && since == 4) begin m_z = p_res == 0; m_n = p_res[31]; end
        end
        @(negedge clk);
        span = pl ? 4 : 2;
        wb = pl && since == 3;
        check("ready", instr_ready, since >= span);
        check("busy", busy, since < span);
        check("addr_a", rf_addr_a, (pl && since == 1) ? p_ra : 5'd0);
        check("addr_b", rf_addr_b, (pl && since == 1) ? p_rb : 5'd0);
        check("alu_op", alu_operation, h_op);
        check("opa", alu_operandA, h_a);
        check("opb", alu_operandB, h_b);
        check("we", rf_we, wb && p_rd != 0);
        check("waddr", rf_waddr, wb ? p_rd : 5'd0);
        check("wdata", rf_wdata, wb ? p_res : 32'd0);
        check("illegal", illegal, !pl && since == 1);
`ifdef ALU_CTRL_FLAGS_EN
        check("flag_z", flag_z, m_z);
        check("flag_n", flag_n, m_n);
`endif
    endtask

    task automatic send(input logic [31:0] ins, input int idle);
        instr_valid = 1; instr = ins;
        step();
        instr_valid = 0;
        repeat (idle) step();
    endtask

    initial begin
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 0; rf[1] = 5; rf[2] = 7; rf[4] = 0;
        rst_n = 0; instr_valid = 0; instr = 0;
        repeat (2) step();
        rst_n = 1;
        step();
        send(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 4);
        check("add_res", p_res, 32'd12);
        send(mk(6'h3F, 5'd3, 5'd1, 5'd2), 2);
        send(mk(OP_SUB, 5'd0, 5'd1, 5'd1), 4);
        instr_valid = 1; instr = mk(OP_ADD, 5'd6, 5'd1, 5'd2);
        repeat (8) step();
        instr_valid = 0;
        repeat (4) step();
        send(mk(OP_ADD, 5'd7, 5'd1, 5'd2), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (4) step();
        send(mk(OP_DECA, 5'd5, 5'd4, 5'd9), 4);
        check("deca_res", p_res, 32'hFFFF_FFFF);
        for (int i = 0; i < 400; i++) begin
            instr_valid = ($urandom % 3) != 0;
            instr = mk(($urandom % 4 == 0) ? 6'($urandom) : legal_ops[$urandom % 24],
                       5'($urandom), 5'($urandom), 5'($urandom));
            rst_n = ($urandom % 50) != 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
